// File: rtl/meter_pkg.sv
// meter_pkg: shared state encodings, BCD digit width and BCD helpers for the parking meter
package meter_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [15:0] MAX_BCD = 16'h9999;
    typedef enum logic [1:0] {
        ST_EXPIRED = 2'd0,
        ST_LOW     = 2'd1,
        ST_NORMAL  = 2'd2
    } state_t;
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/meter_countdown_if.sv
// meter_countdown_if: divided clock levels and button pulses in, BCD count and display controls out
interface meter_countdown_if;
    logic        tick_lvl;
    logic        blink_lvl;
    logic        add1_pulse;
    logic        add2_pulse;
    logic        set1_pulse;
    logic        set2_pulse;
    logic [15:0] digits;
    logic        expired;
    logic        disp_on;
    logic        sec_strobe;
    modport master (
        output tick_lvl, blink_lvl, add1_pulse, add2_pulse, set1_pulse, set2_pulse,
        input  digits, expired, disp_on, sec_strobe
    );
    modport slave (
        input  tick_lvl, blink_lvl, add1_pulse, add2_pulse, set1_pulse, set2_pulse,
        output digits, expired, disp_on, sec_strobe
    );
endinterface

// File: rtl/meter_bcd_alu.sv
// meter_bcd_alu: 4-digit BCD add with saturation, followed by decrement that floors at zero
module meter_bcd_alu
    import meter_pkg::*;
(
    input  logic [15:0] t,
    input  logic [15:0] add_val,
    input  logic [15:0] max_val,
    output logic [15:0] sum,
    output logic [15:0] dec
);
    logic [15:0] raw;
    logic [4:0]  s;
    logic        c;
    logic        b;
    logic [3:0]  d;
    // per-digit carry add; a carry out of the top digit or a value above the ceiling saturates
    always_comb begin
        raw = '0;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, t[i*DIGIT_W +: DIGIT_W]} + {1'b0, add_val[i*DIGIT_W +: DIGIT_W]} + {4'b0, c};
            c = s > 5'd9;
            raw[i*DIGIT_W +: DIGIT_W] = c ? 4'(s - 5'd10) : s[3:0];
        end
        sum = (c || raw > max_val) ? max_val : raw;
    end
    // borrow chain across digits; a zero sum starts with no borrow so it stays zero
    always_comb begin
        dec = sum;
        d = '0;
        b = sum != '0;
        for (int i = 0; i < 4; i++) begin
            d = sum[i*DIGIT_W +: DIGIT_W];
            dec[i*DIGIT_W +: DIGIT_W] = b ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
            b = b && d == 4'd0;
        end
    end
endmodule

// File: rtl/meter_countdown.sv
// meter_countdown: BCD seconds countdown with add/set controls; define LOW_WARN_EN for the flashing low-time state
module meter_countdown
    import meter_pkg::*;
#(
    parameter int ADD1_SEC = 60,
    parameter int ADD2_SEC = 120,
    parameter int SET1_SEC = 16,
    parameter int SET2_SEC = 150,
    parameter int MAX_SEC  = 9999,
    parameter int LOW_SEC  = 180
) (
    input logic clk,
    input logic rst,
    meter_countdown_if.slave bus
);
    localparam logic [15:0] ADD1_B = to_bcd(ADD1_SEC);
    localparam logic [15:0] ADD2_B = to_bcd(ADD2_SEC);
    localparam logic [15:0] SET1_B = to_bcd(SET1_SEC);
    localparam logic [15:0] SET2_B = to_bcd(SET2_SEC);
    localparam logic [15:0] MAX_B  = MAX_SEC >= 9999 ? MAX_BCD : to_bcd(MAX_SEC);
`ifdef LOW_WARN_EN
    localparam logic [15:0] LOW_B  = to_bcd(LOW_SEC);
`endif

    if (MAX_SEC > 9999 || LOW_SEC > 9999) begin : g_param_err
        $error("meter_countdown: MAX_SEC and LOW_SEC must fit in 4 BCD digits");
    end

    logic        tick_q;
    logic        tick_rise;
    logic        disp_n;
    logic        disp_q;
    logic        strobe_q;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [15:0] add_val;
    logic [15:0] sum;
    logic [15:0] dec;
    state_t      state;
    state_t      state_n;

    assign tick_rise = bus.tick_lvl & ~tick_q;

    meter_bcd_alu u_alu (
        .t       (cnt),
        .add_val (add_val),
        .max_val (MAX_B),
        .sum     (sum),
        .dec     (dec)
    );

    // next count by priority set > add(+tick) > tick, then state and display decode from the new count
    always_comb begin
        add_val = bus.add2_pulse ? ADD2_B : bus.add1_pulse ? ADD1_B : '0;
        cnt_n = bus.set2_pulse ? SET2_B
              : bus.set1_pulse ? SET1_B
              : tick_rise ? dec
              : (bus.add1_pulse | bus.add2_pulse) ? sum
              : cnt;
`ifdef LOW_WARN_EN
        state_n = cnt_n == '0 ? ST_EXPIRED : cnt_n < LOW_B ? ST_LOW : ST_NORMAL;
`else
        state_n = cnt_n == '0 ? ST_EXPIRED : ST_NORMAL;
`endif
        disp_n = state_n == ST_EXPIRED ? bus.blink_lvl : state_n == ST_LOW ? bus.tick_lvl : 1'b1;
    end

    // count, state, edge detect and display registers; edge detect loads 1 so a high level after reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b1;
            cnt <= '0;
            state <= ST_EXPIRED;
            disp_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            tick_q <= bus.tick_lvl;
            cnt <= cnt_n;
            state <= state_n;
            disp_q <= disp_n;
            strobe_q <= tick_rise;
        end
    end

    assign bus.digits = cnt;
    assign bus.expired = state == ST_EXPIRED;
    assign bus.disp_on = disp_q;
    assign bus.sec_strobe = strobe_q;
endmodule

// File: tb/tb_meter_countdown.sv
// tb_meter_countdown: directed and random stimulus against an integer-seconds reference model with a scoreboard
module tb_meter_countdown;
    typedef struct {
        logic [15:0] digits;
        logic        expired;
        logic        disp_on;
        logic        sec_strobe;
    } exp_t;

`ifdef LOW_WARN_EN
    localparam bit LOW_EN = 1'b1;
`else
    localparam bit LOW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   t_m = 0;
    bit   tp_m = 1'b1;
    bit   tk = 1'b0;

    meter_countdown_if bus();

    meter_countdown dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // one clock of stimulus; the model advances in whole seconds and the expectation is queued
    task automatic step(input bit r, input bit tick, input bit a1, input bit a2, input bit s1, input bit s2);
        exp_t e;
        bit   rise;
        bit   bl;
        @(negedge clk);
        bl = 1'($urandom_range(0, 1));
        rst = r;
        bus.tick_lvl = tick;
        bus.blink_lvl = bl;
        bus.add1_pulse = a1;
        bus.add2_pulse = a2;
        bus.set1_pulse = s1;
        bus.set2_pulse = s2;
        tk = tick;
        rise = tick && !tp_m;
        if (r) begin
            t_m = 0;
            tp_m = 1'b1;
            e = '{16'h0000, 1'b1, 1'b0, 1'b0};
        end else begin
            if (s2) t_m = 150;
            else if (s1) t_m = 16;
            else begin
                if (a2) t_m = (t_m + 120 > 9999) ? 9999 : t_m + 120;
                else if (a1) t_m = (t_m + 60 > 9999) ? 9999 : t_m + 60;
                if (rise && t_m > 0) t_m--;
            end
            tp_m = tick;
            e.digits = bcd(t_m);
            e.expired = t_m == 0;
            e.disp_on = t_m == 0 ? bl : (LOW_EN && t_m < 180) ? tick : 1'b1;
            e.sec_strobe = rise;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, tk, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic pulses(input bit a1, input bit a2, input bit s1, input bit s2, input int n);
        for (int i = 0; i < n; i++) step(0, tk, a1, a2, s1, s2);
    endtask

    // monitor: every clock after stimulus starts, compare all outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("digits", bus.digits, e.digits);
                check("expired", 16'(bus.expired), 16'(e.expired));
                check("disp_on", 16'(bus.disp_on), 16'(e.disp_on));
                check("sec_strobe", 16'(bus.sec_strobe), 16'(e.sec_strobe));
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        // countdown from set1 to zero, then no wrap below zero
        pulses(0, 0, 1, 0, 1);
        ticks(16);
        ticks(5);
        idle(3);
        // saturation at the ceiling and decrement from it
        pulses(0, 1, 0, 0, 84);
        ticks(49);
        pulses(1, 0, 0, 0, 1);
        pulses(0, 1, 0, 0, 1);
        ticks(1);
        // borrow chains and add coincident with a tick
        pulses(0, 0, 0, 1, 1);
        ticks(51);
        pulses(1, 0, 0, 0, 16);
        ticks(60);
        pulses(0, 0, 1, 0, 1);
        pulses(1, 0, 0, 0, 3);
        ticks(15);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // set2 beats add2 and tick in the same cycle, then the display follows the tick level
        step(0, 1, 0, 1, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 0);
        idle(3);
        ticks(2);
        // reset mid-count while the tick level is high
        pulses(0, 0, 0, 1, 1);
        pulses(0, 1, 0, 0, 3);
        ticks(9);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0 ? !tk : tk,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 79) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
